// File: rtl/mem_stage_ctrl_pkg.sv
// Memory-stage shared definitions.
// State encoding and pipeline widths.
package mem_stage_ctrl_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_timeout_ctr.sv
// Memory request watchdog counter.
// Load-clear, enable, terminal count at TIMEOUT.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_nxt;

  // Next count and terminal detect on the value this cycle completes.
  always_comb begin
    cnt_nxt = {1'b0, cnt_q} + (CNT_W+1)'(1);
    tc      = en && (cnt_nxt == (CNT_W+1)'(TIMEOUT));
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_nxt[CNT_W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller between EX/MEM and MEM/WB.
// Issues data-memory requests, stalls upstream, builds the MEM/WB bundle.
module mem_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_plus_two_pc,
  input  logic [mem_stage_ctrl_pkg::REG_ADDR_W-1:0] ex_write_register,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_link,
  input  logic              ex_halt,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic              mem_err,
  output logic              stall_out,
  output logic [DATA_W-1:0] wb_memory_out,
  output logic [DATA_W-1:0] wb_x_out,
  output logic [DATA_W-1:0] wb_plus_two_pc,
  output logic [mem_stage_ctrl_pkg::REG_ADDR_W-1:0] wb_write_register,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              wb_link,
  output logic              wb_halt,
  output logic              err
);

  import mem_stage_ctrl_pkg::*;

  mem_state_e state_q;
  mem_state_e state_d;
  logic       err_q;
  logic       err_d;
  logic       mem_op;
  logic       is_load;
  logic       present;
  logic       stall;
  logic       retire;
  logic       fault;
  logic       ctr_clr;
  logic       ctr_en;
  logic       ctr_tc;

  assign mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
  assign is_load = mem_op & ex_mem_read & ~ex_mem_write;
  assign ctr_en  = (state_q == ST_REQ) | (state_q == ST_WAIT);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .tc  (ctr_tc)
  );

  // Request sequencing: decide present/stall/retire/fault and next state.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    present = 1'b0;
    stall   = 1'b0;
    retire  = 1'b0;
    fault   = 1'b0;
    ctr_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid && !mem_op) begin
          retire = 1'b1;
        end else if (mem_op && ex_addr[0]) begin
          fault = 1'b1;
        end else if (mem_op) begin
          present = 1'b1;
          if (mem_stall) begin
            stall   = 1'b1;
            ctr_clr = 1'b1;
            state_d = ST_REQ;
          end else if (mem_done) begin
            retire = 1'b1;
          end else begin
            stall   = 1'b1;
            ctr_clr = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_REQ: begin
        present = 1'b1;
        if (mem_stall) begin
          if (ctr_tc) fault = 1'b1;
          else        stall = 1'b1;
        end else if (mem_done) begin
          retire = 1'b1;
        end else begin
          stall   = 1'b1;
          ctr_clr = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_done)    retire = 1'b1;
        else if (ctr_tc) fault  = 1'b1;
        else             stall  = 1'b1;
      end
      ST_HALTED: begin
      end
      default: begin
      end
    endcase
    if (retire && mem_op && mem_err) begin
      retire = 1'b0;
      fault  = 1'b1;
    end
    if (retire) begin
      state_d = ex_halt ? ST_HALTED : ST_IDLE;
    end
    if (fault) begin
      state_d = ST_HALTED;
      err_d   = 1'b1;
    end
  end

  // Memory request and MEM/WB bundle, forced to zero during reset.
  always_comb begin
    mem_en            = present & ~rst;
    mem_wr            = mem_en & ex_mem_write;
    mem_addr          = mem_en ? ex_addr  : '0;
    mem_wdata         = mem_en ? ex_wdata : '0;
    stall_out         = stall & ~rst;
    err               = err_q & ~rst;
    wb_memory_out     = '0;
    wb_x_out          = '0;
    wb_plus_two_pc    = '0;
    wb_write_register = '0;
    wb_reg_write      = 1'b0;
    wb_mem_to_reg     = 1'b0;
    wb_link           = 1'b0;
    wb_halt           = 1'b0;
    if (!rst && retire) begin
      wb_memory_out     = is_load ? mem_rdata : '0;
      wb_x_out          = ex_addr;
      wb_plus_two_pc    = ex_plus_two_pc;
      wb_write_register = ex_write_register;
      wb_reg_write      = ex_reg_write;
      wb_mem_to_reg     = ex_mem_to_reg;
      wb_link           = ex_link;
      wb_halt           = ex_halt;
    end
    if (!rst && fault) begin
      wb_halt = 1'b1;
    end
  end

  // State and sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule
